nvram_ioctl: RTL and testbench
==============================

# nvram_ioctl

Services the HPS side of the ioctl interface for the core's non-volatile save memory (EEPROM/high-score backing store). It answers `hps_io` upload reads by fetching words from a core-side memory port. It accepts save-file downloads by writing words into that port. It sits beside `Main` in the emu top, with the same clock as `hps_io`, and stalls the HPS through `ioctl_wait` while the memory transaction is in flight.

## Interface

Parameters:
- `ADDR_WIDTH`, 10: word address width of the save memory (16-bit words; 2 KiB at default).
- `NVRAM_INDEX`, 8'h04: `ioctl_index` value that selects this block.

Ports:
- `clk_sys` in 1: system clock. All logic is on its rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `ioctl_download` in 1: HPS download session active.
- `ioctl_upload` in 1: HPS upload session active.
- `ioctl_index` in 8: file index of the current session.
- `ioctl_addr` in 25: byte address. Word address is `ioctl_addr[ADDR_WIDTH:1]`.
- `ioctl_wr` in 1: one-cycle download write strobe.
- `ioctl_rd` in 1: one-cycle upload read strobe.
- `ioctl_dout` in 16: download data.
- `ioctl_din` out 16: upload data, valid when `ioctl_wait` is low after a read.
- `ioctl_wait` out 1: stalls the HPS.
- `mem_rd` out 1: memory read request.
- `mem_wr` out 1: memory write request.
- `mem_addr` out ADDR_WIDTH: memory word address.
- `mem_din` out 16: memory write data.
- `mem_dout` in 16: memory read data.
- `mem_wait` in 1: memory waitrequest. A request is accepted in a cycle where it is asserted and `mem_wait` is 0.
- `mem_valid` in 1: read data valid, one cycle per accepted read.
- `nvram_written` in 1: pulse from the core when it modifies save memory.
- `busy` out 1: a session is selected. The core must not access save memory while `busy` is high.
- `dirty` out 1: save memory differs from the last uploaded or downloaded image.

## Operation

- Session select: `sel = (ioctl_download | ioctl_upload) & (ioctl_index == NVRAM_INDEX)`. `busy` is `sel` registered.
- If both session flags are high, download takes priority. Upload reads are then ignored.
- In range means `ioctl_addr[24:ADDR_WIDTH+1] == 0`.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ.
- IDLE:
  - `ioctl_rd` & upload & sel & in range: latch the word address, set `ioctl_wait`=1, go to RD_REQ.
  - `ioctl_wr` & download & sel & in range: latch the address and `ioctl_dout`, set `ioctl_wait`=1, go to WR_REQ.
  - Out-of-range read: `ioctl_din` ← 0 next cycle, with no wait and no memory access.
  - Out-of-range write: dropped.
- RD_REQ: hold `mem_rd`=1 and `mem_addr` until `mem_wait`=0, then go to RD_WAIT with `mem_rd`=0.
- RD_WAIT: on `mem_valid`, `ioctl_din` ← `mem_dout`, `ioctl_wait` ← 0, go to IDLE.
- WR_REQ: hold `mem_wr`=1 with address and data until `mem_wait`=0. Then `mem_wr` ← 0, `ioctl_wait` ← 0, go to IDLE.
- Strobes arriving outside IDLE are ignored; the protocol forbids them.
- A strobe from a non-selected index is ignored in every state.
- Session end mid-transaction: the transaction runs to completion. The memory request is never withdrawn, and `ioctl_wait` falls on completion.
- `dirty`:
  - Set on `nvram_written`.
  - Cleared on the falling edge of `sel` after an upload in which at least one read completed.
  - Cleared on the falling edge of `sel` after a download in which at least one write completed.
  - Set wins over clear in the same cycle.
- Reset (any time, including mid-transaction):
  - State goes to IDLE.
  - `ioctl_wait`, `mem_rd`, `mem_wr`, `busy`, `dirty` = 0.
  - `ioctl_din`, `mem_addr`, `mem_din` = 0.
  - Pending transaction flags are cleared.

## Timing

- Read, with the strobe in cycle 0:
  - `ioctl_wait`=1 and `mem_rd`=1 from cycle 1.
  - If accepted in cycle 1, RD_WAIT starts in cycle 2.
  - `mem_valid` in cycle N gives `ioctl_din` valid and `ioctl_wait`=0 in cycle N+1.
  - Minimum: `mem_valid` in cycle 2 gives wait low in cycle 3.
- Write, with the strobe in cycle 0:
  - `mem_wr`=1 from cycle 1.
  - Accepted in cycle K gives `ioctl_wait`=0 and `mem_wr`=0 in cycle K+1.
  - Minimum: wait high for exactly 1 cycle (cycle 1).
- Out-of-range read: `ioctl_din`=0 in cycle 1, `ioctl_wait` stays 0.
- `busy` lags `sel` by 1 cycle. `dirty` updates 1 cycle after its trigger.
- `mem_addr` and `mem_din` are stable for every cycle the request is asserted.

## Test plan

- Upload read: index 4, `ioctl_addr`=0x00A, memory returns 0xBEEF with `mem_wait` low and `mem_valid` 2 cycles after acceptance. Required: `mem_addr`=5, `ioctl_wait` high for cycles 1–3, then `ioctl_din`=0xBEEF with wait low.
- Download write with backpressure: `ioctl_addr`=0x7FE, `ioctl_dout`=0x1234, `mem_wait` high for 3 cycles. Required: `mem_wr` held 4 cycles with `mem_addr`=0x3FF and `mem_din`=0x1234 throughout; wait falls the cycle after acceptance.
- Range and index filtering:
  - Read at `ioctl_addr`=0x800 returns 0 with no `mem_rd` and no wait.
  - Write with index 0 produces no `mem_wr`.
- Dirty tracking:
  - `nvram_written` pulse gives `dirty`=1.
  - An upload session with one completed read, then `ioctl_upload` falling, gives `dirty`=0.
  - `nvram_written` coincident with that clear gives `dirty`=1.
- Session abort: drop `ioctl_upload` in RD_WAIT. Required: the read still completes on `mem_valid`, `ioctl_wait` then falls, FSM returns to IDLE.
- Reset mid-WR_REQ: assert `RESET` asynchronously. Required: `mem_wr`, `ioctl_wait`, `busy`, `dirty` go to 0 immediately. After release, the next write strobe is serviced normally.

Source files
------------

// File: rtl/nvram_ioctl.sv
// HPS ioctl bridge for the core's save memory: services upload reads and
// download writes through a core-side word memory port and tracks dirtiness.
module nvram_ioctl #(
  parameter int         ADDR_WIDTH  = 10,
  parameter logic [7:0] NVRAM_INDEX = 8'h04
) (
  input  logic                  clk_sys,
  input  logic                  RESET,
  input  logic                  ioctl_download,
  input  logic                  ioctl_upload,
  input  logic [7:0]            ioctl_index,
  input  logic [24:0]           ioctl_addr,
  input  logic                  ioctl_wr,
  input  logic                  ioctl_rd,
  input  logic [15:0]           ioctl_dout,
  output logic [15:0]           ioctl_din,
  output logic                  ioctl_wait,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_din,
  input  logic [15:0]           mem_dout,
  input  logic                  mem_wait,
  input  logic                  mem_valid,
  input  logic                  nvram_written,
  output logic                  busy,
  output logic                  dirty
);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [15:0]           rdata_q, rdata_d;
  logic                  busy_q;
  logic                  dirty_q, dirty_d;
  logic                  done_q, done_d;

  logic sel, inRange, rdStrobe, wrStrobe, rdDone, wrDone, selFall, selRise;
  logic unusedAddrBit;

  assign unusedAddrBit = ioctl_addr[0];

  assign sel      = (ioctl_download | ioctl_upload) & (ioctl_index == NVRAM_INDEX);
  assign inRange  = (ioctl_addr[24:ADDR_WIDTH+1] == '0);
  // Download wins when both session flags are up, so reads need upload alone.
  assign wrStrobe = ioctl_wr & ioctl_download & sel;
  assign rdStrobe = ioctl_rd & ioctl_upload & ~ioctl_download & sel;
  assign rdDone   = (state_q == RD_WAIT) & mem_valid;
  assign wrDone   = (state_q == WR_REQ) & ~mem_wait;
  assign selFall  = busy_q & ~sel;
  assign selRise  = ~busy_q & sel;

  assign ioctl_wait = (state_q != IDLE);
  assign ioctl_din  = rdata_q;
  assign mem_addr   = addr_q;
  assign mem_din    = wdata_q;
  assign busy       = busy_q;
  assign dirty      = dirty_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wrStrobe) begin
          if (inRange) begin
            addr_d  = ioctl_addr[ADDR_WIDTH:1];
            wdata_d = ioctl_dout;
            state_d = WR_REQ;
          end
        end else if (rdStrobe) begin
          if (inRange) begin
            addr_d  = ioctl_addr[ADDR_WIDTH:1];
            state_d = RD_REQ;
          end else begin
            rdata_d = 16'h0000;
          end
        end
      end
      RD_REQ: begin
        mem_rd = 1'b1;
        if (!mem_wait) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_valid) begin
          rdata_d = mem_dout;
          state_d = IDLE;
        end
      end
      WR_REQ: begin
        mem_wr = 1'b1;
        if (!mem_wait) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A session only earns a dirty clear if it actually moved data; the flag is
  // rearmed when the next session opens.
  always_comb begin
    done_d = done_q;
    if (selRise) done_d = 1'b0;
    if (rdDone || wrDone) done_d = 1'b1;
    dirty_d = dirty_q;
    if (selFall && (done_q || rdDone || wrDone)) dirty_d = 1'b0;
    if (nvram_written) dirty_d = 1'b1;
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      dirty_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      busy_q  <= sel;
      dirty_q <= dirty_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_nvram_ioctl.sv
// Directed bench for nvram_ioctl: reads, writes, filtering, dirty tracking,
// session abort and asynchronous reset, with hand-computed expectations.
module tb_nvram_ioctl;

  logic        clk_sys = 1'b0;
  logic        RESET;
  logic        ioctl_download, ioctl_upload, ioctl_wr, ioctl_rd;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout, ioctl_din;
  logic        ioctl_wait, mem_rd, mem_wr;
  logic [9:0]  mem_addr;
  logic [15:0] mem_din, mem_dout;
  logic        mem_wait, mem_valid, nvram_written, busy, dirty;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_sys = ~clk_sys;

  nvram_ioctl dut (
    .clk_sys(clk_sys), .RESET(RESET),
    .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd), .ioctl_dout(ioctl_dout),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_wait(mem_wait), .mem_valid(mem_valid),
    .nvram_written(nvram_written), .busy(busy), .dirty(dirty)
  );

  // Advance one clock; returns 1ns after the edge so outputs are settled.
  task automatic applyStimulus();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RESET = 1'b1;
    ioctl_download = 0; ioctl_upload = 0; ioctl_wr = 0; ioctl_rd = 0;
    ioctl_index = 8'h00; ioctl_addr = '0; ioctl_dout = '0;
    mem_dout = '0; mem_wait = 0; mem_valid = 0; nvram_written = 0;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_wait", ioctl_wait, 0);
    checkOutput("rst_memrd", mem_rd, 0);
    checkOutput("rst_memwr", mem_wr, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_dirty", dirty, 0);
    checkOutput("rst_din", ioctl_din, 0);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_memdin", mem_din, 0);
    RESET = 1'b0;
    applyStimulus();

    // Core modifies save memory.
    nvram_written = 1;
    applyStimulus();
    nvram_written = 0;
    checkOutput("dirty_set", dirty, 1);

    // Upload read of byte 0x00A, data two cycles after acceptance.
    ioctl_upload = 1; ioctl_index = 8'h04; ioctl_addr = 25'h00A;
    applyStimulus();
    checkOutput("busy_up", busy, 1);
    ioctl_rd = 1;
    applyStimulus();
    ioctl_rd = 0;
    checkOutput("rd_c1_wait", ioctl_wait, 1);
    checkOutput("rd_c1_memrd", mem_rd, 1);
    checkOutput("rd_c1_addr", mem_addr, 10'd5);
    applyStimulus();
    checkOutput("rd_c2_wait", ioctl_wait, 1);
    checkOutput("rd_c2_memrd", mem_rd, 0);
    applyStimulus();
    checkOutput("rd_c3_wait", ioctl_wait, 1);
    mem_valid = 1; mem_dout = 16'hBEEF;
    applyStimulus();
    mem_valid = 0; mem_dout = 16'h0000;
    checkOutput("rd_c4_wait", ioctl_wait, 0);
    checkOutput("rd_c4_din", ioctl_din, 16'hBEEF);
    checkOutput("dirty_hold", dirty, 1);
    ioctl_upload = 0;
    applyStimulus();
    checkOutput("busy_drop", busy, 0);
    checkOutput("dirty_clr_up", dirty, 0);

    // Minimum-latency read, then session end coincident with a core write.
    ioctl_upload = 1; ioctl_addr = 25'h002;
    applyStimulus();
    ioctl_rd = 1;
    applyStimulus();
    ioctl_rd = 0;
    checkOutput("rdmin_addr", mem_addr, 10'd1);
    applyStimulus();
    mem_valid = 1; mem_dout = 16'h5A5A;
    applyStimulus();
    mem_valid = 0;
    checkOutput("rdmin_wait", ioctl_wait, 0);
    checkOutput("rdmin_din", ioctl_din, 16'h5A5A);
    ioctl_upload = 0; nvram_written = 1;
    applyStimulus();
    nvram_written = 0;
    checkOutput("dirty_setwins", dirty, 1);

    // Out-of-range read returns zero without touching memory.
    ioctl_upload = 1; ioctl_addr = 25'h800;
    applyStimulus();
    ioctl_rd = 1;
    applyStimulus();
    ioctl_rd = 0;
    checkOutput("oor_din", ioctl_din, 0);
    checkOutput("oor_wait", ioctl_wait, 0);
    checkOutput("oor_memrd", mem_rd, 0);
    ioctl_upload = 0;
    applyStimulus();

    // Download write at 0x7FE with three cycles of backpressure.
    ioctl_download = 1; ioctl_addr = 25'h7FE; ioctl_dout = 16'h1234;
    applyStimulus();
    ioctl_wr = 1; mem_wait = 1;
    applyStimulus();
    ioctl_wr = 0; ioctl_dout = 16'h0000;
    for (int i = 1; i <= 4; i++) begin
      mem_wait = (i < 4);
      checkOutput($sformatf("wr_c%0d_memwr", i), mem_wr, 1);
      checkOutput($sformatf("wr_c%0d_addr", i), mem_addr, 10'h3FF);
      checkOutput($sformatf("wr_c%0d_din", i), mem_din, 16'h1234);
      checkOutput($sformatf("wr_c%0d_wait", i), ioctl_wait, 1);
      applyStimulus();
    end
    mem_wait = 0;
    checkOutput("wr_done_memwr", mem_wr, 0);
    checkOutput("wr_done_wait", ioctl_wait, 0);
    ioctl_download = 0;
    applyStimulus();
    checkOutput("dirty_clr_dl", dirty, 0);

    // Write strobe from another index is ignored.
    ioctl_download = 1; ioctl_index = 8'h00; ioctl_addr = 25'h010; ioctl_wr = 1;
    applyStimulus();
    ioctl_wr = 0;
    checkOutput("idx_memwr", mem_wr, 0);
    checkOutput("idx_wait", ioctl_wait, 0);
    checkOutput("idx_busy", busy, 0);
    ioctl_download = 0; ioctl_index = 8'h04;
    applyStimulus();

    // Upload dropped while waiting for read data.
    ioctl_upload = 1; ioctl_addr = 25'h014;
    applyStimulus();
    ioctl_rd = 1;
    applyStimulus();
    ioctl_rd = 0;
    applyStimulus();
    ioctl_upload = 0;
    applyStimulus();
    checkOutput("abort_wait", ioctl_wait, 1);
    mem_valid = 1; mem_dout = 16'hCAFE;
    applyStimulus();
    mem_valid = 0;
    checkOutput("abort_done_wait", ioctl_wait, 0);
    checkOutput("abort_din", ioctl_din, 16'hCAFE);
    checkOutput("abort_memrd", mem_rd, 0);

    // Asynchronous reset in the middle of a stalled write.
    nvram_written = 1;
    applyStimulus();
    nvram_written = 0;
    ioctl_download = 1; ioctl_addr = 25'h020; ioctl_dout = 16'hABCD; mem_wait = 1;
    applyStimulus();
    ioctl_wr = 1;
    applyStimulus();
    ioctl_wr = 0;
    checkOutput("rstw_memwr_pre", mem_wr, 1);
    #2 RESET = 1'b1;
    #1;
    checkOutput("rstw_memwr", mem_wr, 0);
    checkOutput("rstw_wait", ioctl_wait, 0);
    checkOutput("rstw_busy", busy, 0);
    checkOutput("rstw_dirty", dirty, 0);
    checkOutput("rstw_addr", mem_addr, 0);
    #1 RESET = 1'b0;
    mem_wait = 0;
    applyStimulus();
    ioctl_addr = 25'h030; ioctl_dout = 16'h0F0F; ioctl_wr = 1;
    applyStimulus();
    ioctl_wr = 0;
    checkOutput("post_memwr", mem_wr, 1);
    checkOutput("post_addr", mem_addr, 10'h018);
    checkOutput("post_din", mem_din, 16'h0F0F);
    checkOutput("post_wait", ioctl_wait, 1);
    applyStimulus();
    checkOutput("post_done_memwr", mem_wr, 0);
    checkOutput("post_done_wait", ioctl_wait, 0);
    ioctl_download = 0;
    applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
